// File: rtl/isa_pkg.sv
// Shared ISA definitions for the matrix-multiply processor: field widths,
// opcode values and the fetch sequencer state encoding.
package isa_pkg;

    localparam int INSTR_W   = 17;
    localparam int OPC_W     = 5;
    localparam int OPERAND_W = 12;

    localparam logic [OPC_W-1:0] OPC_LDAC   = 5'd3;
    localparam logic [OPC_W-1:0] OPC_LDIAC  = 5'd5;
    localparam logic [OPC_W-1:0] OPC_STAC   = 5'd8;
    localparam logic [OPC_W-1:0] OPC_MVAC   = 5'd9;
    localparam logic [OPC_W-1:0] OPC_MVACAR = 5'd10;
    localparam logic [OPC_W-1:0] OPC_MVACR1 = 5'd11;
    localparam logic [OPC_W-1:0] OPC_MVACR2 = 5'd12;
    localparam logic [OPC_W-1:0] OPC_MVACR3 = 5'd13;
    localparam logic [OPC_W-1:0] OPC_MVACR4 = 5'd14;
    localparam logic [OPC_W-1:0] OPC_MVR1AC = 5'd15;
    localparam logic [OPC_W-1:0] OPC_MVR2AC = 5'd16;
    localparam logic [OPC_W-1:0] OPC_MVR3AC = 5'd17;
    localparam logic [OPC_W-1:0] OPC_MVR4AC = 5'd18;
    localparam logic [OPC_W-1:0] OPC_ADD    = 5'd19;
    localparam logic [OPC_W-1:0] OPC_MULT   = 5'd20;
    localparam logic [OPC_W-1:0] OPC_LSHIFT = 5'd21;
    localparam logic [OPC_W-1:0] OPC_SUB    = 5'd22;
    localparam logic [OPC_W-1:0] OPC_INAC   = 5'd23;
    localparam logic [OPC_W-1:0] OPC_JPNZ   = 5'd24;
    localparam logic [OPC_W-1:0] OPC_JMPZ   = 5'd26;
    localparam logic [OPC_W-1:0] OPC_NOP    = 5'd28;
    localparam logic [OPC_W-1:0] OPC_CLAC   = 5'd30;
    localparam logic [OPC_W-1:0] OPC_ENDOP  = 5'd31;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_ISSUE = 3'd1,
        FS_WAIT  = 3'd2,
        FS_OUT   = 3'd3,
        FS_DONE  = 3'd4
    } fetch_state_e;

    function automatic logic is_endop(input logic [OPC_W-1:0] opc);
        return (opc == OPC_ENDOP);
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, hides the 1-cycle memory read
// latency and hands each word to the decoder over valid/ready.
module fetch_sequencer #(
    parameter int ADDR_W     = 12,
    parameter int INSTR_W    = 17,
    parameter int OPC_W      = 5,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_instr,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_en,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   instr_count
);
    import isa_pkg::*;

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ADDR_W-1:0]  pc_inc_s;
    logic               endop_s;

    assign pc_inc_s = pc_q + PC_ONE;
    assign endop_s  = is_endop(instr_q[INSTR_W-1 -: OPC_W]);

    // Next-state and next-output logic for the fetch FSM.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;

        case (state_q)
            FS_IDLE, FS_DONE: begin
                if (start) begin
                    pc_d       = START_PC;
                    mem_addr_d = START_PC;
                    cnt_d      = {CNT_W{1'b0}};
                    state_d    = FS_ISSUE;
                end else begin
                    state_d = state_q;
                end
            end
            FS_ISSUE: begin
                if (redirect_en) begin
                    pc_d       = redirect_addr;
                    mem_addr_d = redirect_addr;
                    state_d    = FS_ISSUE;
                end else begin
                    state_d = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (redirect_en) begin
                    pc_d       = redirect_addr;
                    mem_addr_d = redirect_addr;
                    state_d    = FS_ISSUE;
                end else begin
                    instr_d    = mem_instr;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    state_d    = FS_OUT;
                end
            end
            FS_OUT: begin
                // A redirect wins over a same-cycle accept: the word is dropped uncounted.
                if (redirect_en) begin
                    pc_d       = redirect_addr;
                    mem_addr_d = redirect_addr;
                    valid_d    = 1'b0;
                    state_d    = FS_ISSUE;
                end else if (instr_ready) begin
                    cnt_d   = cnt_q + CNT_ONE;
                    valid_d = 1'b0;
                    if (endop_s) begin
                        done_d  = 1'b1;
                        state_d = FS_DONE;
                    end else begin
                        pc_d       = pc_inc_s;
                        mem_addr_d = pc_inc_s;
                        state_d    = FS_ISSUE;
                    end
                end else begin
                    state_d = FS_OUT;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = FS_IDLE;
            end
        endcase

        busy_d = (state_d != FS_IDLE) && (state_d != FS_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FS_IDLE;
            pc_q       <= START_PC;
            mem_addr_q <= {ADDR_W{1'b0}};
            instr_q    <= {INSTR_W{1'b0}};
            instr_pc_q <= {ADDR_W{1'b0}};
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized
// run scored against a transaction-level model of the fetch rules.
module tb_fetch_sequencer;
    import isa_pkg::*;

    localparam int AW = 12;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst, start0, start1, ready, redir;
    logic [AW-1:0] raddr;
    logic [AW-1:0] mem_addr0, mem_addr1, instr_pc0, instr_pc1;
    logic [INSTR_W-1:0] mem_instr0, mem_instr1, instr0, instr1;
    logic valid0, valid1, busy0, busy1, done0, done1;
    logic [CW-1:0] count0, count1;
    logic [INSTR_W-1:0] ram [4096];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Registered-read instruction memories, one port per DUT.
    always @(posedge clk) begin
        mem_instr0 <= ram[mem_addr0];
        mem_instr1 <= ram[mem_addr1];
    end

    fetch_sequencer #(.ADDR_W(12), .INSTR_W(17), .OPC_W(5), .START_ADDR(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .mem_addr(mem_addr0), .mem_instr(mem_instr0),
        .instr(instr0), .instr_pc(instr_pc0), .instr_valid(valid0), .instr_ready(ready),
        .redirect_en(redir), .redirect_addr(raddr), .busy(busy0), .done(done0),
        .instr_count(count0));

    fetch_sequencer #(.ADDR_W(12), .INSTR_W(17), .OPC_W(5), .START_ADDR(4095), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mem_addr(mem_addr1), .mem_instr(mem_instr1),
        .instr(instr1), .instr_pc(instr_pc1), .instr_valid(valid1), .instr_ready(ready),
        .redirect_en(redir), .redirect_addr(raddr), .busy(busy1), .done(done1),
        .instr_count(count1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog();
        ram[0] = {OPC_CLAC, 12'd0};
        ram[1] = {OPC_MVACR1, 12'd0};
        ram[2] = {OPC_LDIAC, 12'd4094};
        ram[3] = {OPC_ENDOP, 12'd0};
    endtask

    task automatic test_reset();
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; ready = 1'b0; redir = 1'b0; raddr = 12'd0;
        #13;
        n_checks++; if ({mem_addr0, instr0, instr_pc0} !== 41'd0) begin n_errors++;
            $display("FAIL reset_data: got addr=%0h instr=%0h pc=%0h, want 0", mem_addr0, instr0, instr_pc0); end
        n_checks++; if ({valid0, busy0, done0} !== 3'b000) begin n_errors++;
            $display("FAIL reset_flags: got v/b/d=%b%b%b, want 000", valid0, busy0, done0); end
        n_checks++; if (count0 !== 16'd0 || busy1 !== 1'b0) begin n_errors++;
            $display("FAIL reset_count: got count=%0d busy1=%b, want 0/0", count0, busy1); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_program();
        logic exp_v;
        int idx;
        load_prog();
        ready = 1'b1;
        start0 = 1'b1; tick(); start0 = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            exp_v = (c % 3 == 0) && (c <= 12);
            idx = c / 3 - 1;
            n_checks++; if (valid0 !== exp_v) begin n_errors++;
                $display("FAIL prog_valid c=%0d: got %b, want %b", c, valid0, exp_v); end
            if (exp_v) begin
                n_checks++; if (instr_pc0 !== AW'(idx) || instr0 !== ram[idx]) begin n_errors++;
                    $display("FAIL prog_word c=%0d: got pc=%0d instr=%0h, want pc=%0d instr=%0h",
                             c, instr_pc0, instr0, idx, ram[idx]); end
            end
            n_checks++; if (done0 !== (c == 13) || busy0 !== (c < 13)) begin n_errors++;
                $display("FAIL prog_done_busy c=%0d: got done=%b busy=%b", c, done0, busy0); end
            tick();
        end
        n_checks++; if (count0 !== 16'd4) begin n_errors++;
            $display("FAIL prog_count: got %0d, want 4", count0); end
    endtask

    task automatic test_stall();
        ready = 1'b0;
        start0 = 1'b1; tick(); start0 = 1'b0;
        tick(); tick();
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (valid0 !== 1'b1 || instr0 !== 17'h1E000) begin n_errors++;
                $display("FAIL stall_hold k=%0d: got v=%b instr=%0h, want 1/1e000", k, valid0, instr0); end
            n_checks++; if (mem_addr0 !== 12'd0 || count0 !== 16'd0) begin n_errors++;
                $display("FAIL stall_addr k=%0d: got addr=%0d count=%0d, want 0/0", k, mem_addr0, count0); end
            tick();
        end
        ready = 1'b1;
        tick();
        n_checks++; if (count0 !== 16'd1 || valid0 !== 1'b0 || mem_addr0 !== 12'd1) begin n_errors++;
            $display("FAIL stall_accept: got count=%0d v=%b addr=%0d, want 1/0/1", count0, valid0, mem_addr0); end
        for (int k = 0; k < 40 && !done0; k++) tick();
        n_checks++; if (done0 !== 1'b1 || count0 !== 16'd4) begin n_errors++;
            $display("FAIL stall_done: got done=%b count=%0d, want 1/4", done0, count0); end
    endtask

    task automatic test_redirect();
        ram[47] = {OPC_NOP, 12'h0AB};
        ready = 1'b1;
        start0 = 1'b1; tick(); start0 = 1'b0;
        redir = 1'b1; raddr = 12'd47; tick(); redir = 1'b0;
        n_checks++; if (mem_addr0 !== 12'd47) begin n_errors++;
            $display("FAIL redir_issue_addr: got %0d, want 47", mem_addr0); end
        tick(); tick();
        n_checks++; if (valid0 !== 1'b1 || instr_pc0 !== 12'd47 || instr0 !== ram[47]) begin n_errors++;
            $display("FAIL redir_present47: got v=%b pc=%0d instr=%0h", valid0, instr_pc0, instr0); end
        redir = 1'b1; raddr = 12'd0; tick(); redir = 1'b0;
        n_checks++; if (valid0 !== 1'b0 || count0 !== 16'd0 || mem_addr0 !== 12'd0) begin n_errors++;
            $display("FAIL redir_drop: got v=%b count=%0d addr=%0d, want 0/0/0", valid0, count0, mem_addr0); end
        tick(); tick();
        n_checks++; if (valid0 !== 1'b1 || instr_pc0 !== 12'd0 || instr0 !== ram[0]) begin n_errors++;
            $display("FAIL redir_refetch: got v=%b pc=%0d instr=%0h, want 1/0/%0h", valid0, instr_pc0, instr0, ram[0]); end
        for (int k = 0; k < 40 && !done0; k++) tick();
        n_checks++; if (done0 !== 1'b1 || count0 !== 16'd4) begin n_errors++;
            $display("FAIL redir_done: got done=%b count=%0d, want 1/4", done0, count0); end
    endtask

    task automatic test_async_reset();
        ready = 1'b1;
        start0 = 1'b1; tick(); start0 = 1'b0;
        tick();
        #3 rst = 1'b1;
        #1;
        n_checks++; if ({instr0, instr_pc0, mem_addr0} !== 41'd0 || count0 !== 16'd0) begin n_errors++;
            $display("FAIL areset_data: got instr=%0h pc=%0d addr=%0d count=%0d", instr0, instr_pc0, mem_addr0, count0); end
        n_checks++; if ({valid0, busy0, done0} !== 3'b000) begin n_errors++;
            $display("FAIL areset_flags: got v/b/d=%b%b%b, want 000", valid0, busy0, done0); end
        #1 rst = 1'b0;
        tick();
        start0 = 1'b1; tick(); start0 = 1'b0;
        tick(); tick();
        n_checks++; if (valid0 !== 1'b1 || instr_pc0 !== 12'd0 || instr0 !== ram[0]) begin n_errors++;
            $display("FAIL areset_refetch: got v=%b pc=%0d instr=%0h", valid0, instr_pc0, instr0); end
        for (int k = 0; k < 40 && !done0; k++) tick();
        n_checks++; if (done0 !== 1'b1) begin n_errors++;
            $display("FAIL areset_done: got done=%b, want 1", done0); end
    endtask

    task automatic test_busy_ignore();
        ready = 1'b1;
        start0 = 1'b1; tick();
        tick(); start0 = 1'b0;
        n_checks++; if (mem_addr0 !== 12'd0 || busy0 !== 1'b1 || valid0 !== 1'b0) begin n_errors++;
            $display("FAIL busy_start_ignored: got addr=%0d busy=%b v=%b", mem_addr0, busy0, valid0); end
        tick();
        n_checks++; if (valid0 !== 1'b1 || instr_pc0 !== 12'd0) begin n_errors++;
            $display("FAIL busy_start_timing: got v=%b pc=%0d, want 1/0", valid0, instr_pc0); end
        for (int k = 0; k < 40 && !done0; k++) tick();
        tick();
        redir = 1'b1; raddr = 12'd123;
        tick(); tick(); tick();
        redir = 1'b0;
        n_checks++; if (mem_addr0 !== 12'd3 || busy0 !== 1'b0 || valid0 !== 1'b0 || count0 !== 16'd4) begin n_errors++;
            $display("FAIL idle_redirect_ignored: got addr=%0d busy=%b v=%b count=%0d", mem_addr0, busy0, valid0, count0); end
        n_checks++; if (mem_addr1 !== 12'd0 || busy1 !== 1'b0) begin n_errors++;
            $display("FAIL idle_redirect_dut1: got addr=%0d busy=%b, want 0/0", mem_addr1, busy1); end
    endtask

    task automatic test_wrap();
        logic exp_v;
        ram[4095] = {OPC_NOP, 12'h123};
        ram[0]    = {OPC_ENDOP, 12'h000};
        ready = 1'b1;
        start1 = 1'b1; tick(); start1 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            exp_v = (c == 3) || (c == 6);
            n_checks++; if (valid1 !== exp_v) begin n_errors++;
                $display("FAIL wrap_valid c=%0d: got %b, want %b", c, valid1, exp_v); end
            if (c == 3) begin
                n_checks++; if (instr_pc1 !== 12'd4095 || instr1 !== ram[4095]) begin n_errors++;
                    $display("FAIL wrap_first: got pc=%0d instr=%0h", instr_pc1, instr1); end
            end
            if (c == 6) begin
                n_checks++; if (instr_pc1 !== 12'd0 || instr1 !== ram[0]) begin n_errors++;
                    $display("FAIL wrap_second: got pc=%0d instr=%0h", instr_pc1, instr1); end
            end
            n_checks++; if (done1 !== (c == 7)) begin n_errors++;
                $display("FAIL wrap_done c=%0d: got %b", c, done1); end
            tick();
        end
        n_checks++; if (count1 !== 16'd2) begin n_errors++;
            $display("FAIL wrap_count: got %0d, want 2", count1); end
    endtask

    task automatic test_random();
        bit m_run, m_done, m_valid;
        int m_pc, m_cnt, m_gap, n_done;
        for (int a = 0; a < 64; a++) ram[a] = {5'($urandom_range(0, 31)), 12'($urandom)};
        start0 = 1'b0; redir = 1'b0; ready = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        m_run = 1'b0; m_done = 1'b0; m_pc = 0; m_cnt = 0; m_gap = 0; n_done = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            start0 = ($urandom_range(0, 15) == 0);
            ready  = ($urandom_range(0, 3) != 0);
            redir  = ($urandom_range(0, 9) == 0);
            raddr  = 12'($urandom_range(0, 63));
            m_valid = m_run && (m_gap >= 3);
            if (!m_run) begin
                m_done = 1'b0;
                if (start0) begin m_run = 1'b1; m_pc = 0; m_cnt = 0; m_gap = 1; end
            end else if (redir) begin
                m_pc = int'(raddr); m_gap = 1; m_done = 1'b0;
            end else if (m_valid && ready) begin
                m_cnt = (m_cnt + 1) % 65536;
                if (ram[m_pc][16:12] == OPC_ENDOP) begin
                    m_run = 1'b0; m_done = 1'b1; n_done++;
                end else begin
                    m_pc = (m_pc + 1) % 4096; m_gap = 1; m_done = 1'b0;
                end
            end else begin
                m_gap = m_gap + 1; m_done = 1'b0;
            end
            tick();
            m_valid = m_run && (m_gap >= 3);
            n_checks++; if (valid0 !== m_valid || busy0 !== m_run || done0 !== m_done) begin n_errors++;
                $display("FAIL rand_flags cyc=%0d: got v/b/d=%b%b%b, want %b%b%b",
                         cyc, valid0, busy0, done0, m_valid, m_run, m_done); end
            n_checks++; if (count0 !== CW'(m_cnt)) begin n_errors++;
                $display("FAIL rand_count cyc=%0d: got %0d, want %0d", cyc, count0, m_cnt); end
            if (m_run) begin
                n_checks++; if (mem_addr0 !== AW'(m_pc)) begin n_errors++;
                    $display("FAIL rand_addr cyc=%0d: got %0d, want %0d", cyc, mem_addr0, m_pc); end
            end
            if (m_valid) begin
                n_checks++; if (instr_pc0 !== AW'(m_pc) || instr0 !== ram[m_pc]) begin n_errors++;
                    $display("FAIL rand_word cyc=%0d: got pc=%0d instr=%0h, want pc=%0d instr=%0h",
                             cyc, instr_pc0, instr0, m_pc, ram[m_pc]); end
            end
        end
        start0 = 1'b0; redir = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) ram[a] = {OPC_NOP, 12'd0};
        test_reset();
        test_program();
        test_stall();
        test_redirect();
        test_async_reset();
        test_busy_ignore();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
